// File: rtl/ysyx_24100006_hazard_ctrl_pkg.sv
// rtl/ysyx_24100006_hazard_ctrl_pkg.sv - shared types and sizes for the ID-stage hazard controller
package ysyx_24100006_hazard_ctrl_pkg;

   localparam int NR_REG = 16;
   localparam int REG_W  = $clog2(NR_REG);
   localparam int CNT_W  = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // RUN: normal issue; DRAIN: wait for the pipe to empty before fence.i/ebreak;
   // ICFL: I-cache invalidation then single fence.i issue; HALT: ebreak parked.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ICFL  = 2'd2,
      ST_HALT  = 2'd3
   } hz_state_e;

endpackage

// File: rtl/ysyx_24100006_gpr_scoreboard.sv
// rtl/ysyx_24100006_gpr_scoreboard.sv - per-GPR pending-write counters with RAW hazard detection
module ysyx_24100006_gpr_scoreboard
   import ysyx_24100006_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_en,
   input  logic [REG_W-1:0] inc_rd,
   input  logic             dec_en,
   input  logic [REG_W-1:0] dec_rd,
   input  logic             kill_en,
   input  logic [REG_W-1:0] kill_rd,
   input  logic             chk_valid,
   input  logic             rs1_used,
   input  logic [REG_W-1:0] rs1,
   input  logic             rs2_used,
   input  logic [REG_W-1:0] rs2,
   input  logic             rd_wr,
   input  logic [REG_W-1:0] rd,
   output logic             hazard,
   output logic             empty
);

   // Counters are updated through a biased sum so -2..+1 deltas clamp without signed math.
   localparam int SUM_W = CNT_W + 2;
   localparam logic [SUM_W-1:0] BIAS    = SUM_W'(2);
   localparam logic [SUM_W-1:0] SUM_TOP = SUM_W'(2) + SUM_W'(CNT_MAX);

   logic [CNT_W-1:0] cnt_q [NR_REG];
   logic [CNT_W-1:0] cnt_d [NR_REG];

   // Next counter values: inc from issue, dec from writeback, dec from redirect kill; saturating.
   always_comb begin
      logic [SUM_W-1:0] sum;
      for (int i = 0; i < NR_REG; i++) begin
         sum = BIAS + SUM_W'(cnt_q[i]);
         if (inc_en  && inc_rd  == REG_W'(i)) sum = sum + SUM_W'(1);
         if (dec_en  && dec_rd  == REG_W'(i)) sum = sum - SUM_W'(1);
         if (kill_en && kill_rd == REG_W'(i)) sum = sum - SUM_W'(1);
         if (sum < BIAS)         cnt_d[i] = '0;
         else if (sum > SUM_TOP) cnt_d[i] = CNT_MAX;
         else                    cnt_d[i] = CNT_W'(sum - BIAS);
         if (i == 0) cnt_d[i] = '0;
      end
   end

   // Counter storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NR_REG; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NR_REG; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Hazard on pending source reads, or on a destination whose counter is already full.
   always_comb begin
      hazard = chk_valid &
               ((rs1_used & (rs1 != '0) & (cnt_q[rs1] != '0)) |
                (rs2_used & (rs2 != '0) & (cnt_q[rs2] != '0)) |
                (rd_wr    & (rd  != '0) & (cnt_q[rd] == CNT_MAX)));
      empty = 1'b1;
      for (int i = 0; i < NR_REG; i++) begin
         if (cnt_q[i] != '0) empty = 1'b0;
      end
   end

endmodule

// File: rtl/ysyx_24100006_hazard_ctrl.sv
// rtl/ysyx_24100006_hazard_ctrl.sv - ID stall, ID_EXE flush and fence.i/ebreak sequencing
module ysyx_24100006_hazard_ctrl
   import ysyx_24100006_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_gpr_write,
   input  logic             id_is_fence_i,
   input  logic             id_is_break,
   input  logic             idex_in_ready,
   input  logic             idex_out_fire,
   input  logic             wb_fire,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_gpr_write,
   input  logic             redirect_i,
   input  logic             icache_flush_ack,
   output logic             id_issue,
   output logic             idex_flush,
   output logic             ifid_flush,
   output logic             icache_flush_req,
   output logic             halted,
   output logic             busy
);

   hz_state_e        state_q, state_d;
   logic             fence_kind_q, fence_kind_d;
   logic             ack_seen_q, ack_seen_d;
   logic             slot_valid_q, slot_valid_d;
   logic             slot_wr_q, slot_wr_d;
   logic [REG_W-1:0] slot_rd_q, slot_rd_d;
   logic             hazard, sb_empty;
   logic             issue_fire, inc_en, dec_en, kill_en;

   assign issue_fire = id_issue & idex_in_ready;
   assign inc_en     = issue_fire & id_gpr_write & (id_rd != '0);
   assign dec_en     = wb_fire & wb_gpr_write & (wb_rd != '0);
   assign kill_en    = redirect_i & slot_valid_q & slot_wr_q;

   assign idex_flush = redirect_i;
   assign ifid_flush = redirect_i;
   assign halted     = (state_q == ST_HALT);
   assign busy       = (state_q != ST_RUN);

   ysyx_24100006_gpr_scoreboard u_sb (
      .clk       (clk),
      .reset     (reset),
      .inc_en    (inc_en),
      .inc_rd    (id_rd),
      .dec_en    (dec_en),
      .dec_rd    (wb_rd),
      .kill_en   (kill_en),
      .kill_rd   (slot_rd_q),
      .chk_valid (id_valid),
      .rs1_used  (id_rs1_used),
      .rs1       (id_rs1),
      .rs2_used  (id_rs2_used),
      .rs2       (id_rs2),
      .rd_wr     (id_gpr_write),
      .rd        (id_rd),
      .hazard    (hazard),
      .empty     (sb_empty)
   );

   // Issue gating and sequencer next state; fence.i issues once from ICFL as a NOP.
   always_comb begin
      state_d          = state_q;
      fence_kind_d     = fence_kind_q;
      ack_seen_d       = ack_seen_q;
      id_issue         = 1'b0;
      icache_flush_req = 1'b0;
      case (state_q)
         ST_RUN: begin
            id_issue = id_valid & ~hazard & ~redirect_i & ~id_is_fence_i & ~id_is_break;
            if (id_valid & (id_is_fence_i | id_is_break) & ~redirect_i) begin
               state_d      = ST_DRAIN;
               fence_kind_d = id_is_fence_i;
            end
         end
         ST_DRAIN: begin
            if (redirect_i) begin
               state_d = ST_RUN;
            end else if (sb_empty & ~slot_valid_q) begin
               state_d    = fence_kind_q ? ST_ICFL : ST_HALT;
               ack_seen_d = 1'b0;
            end
         end
         ST_ICFL: begin
            icache_flush_req = ~ack_seen_q;
            id_issue         = ack_seen_q & id_valid;
            if (ack_seen_q & id_valid & idex_in_ready) begin
               state_d    = ST_RUN;
               ack_seen_d = 1'b0;
            end else if (icache_flush_ack) begin
               ack_seen_d = 1'b1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // ID_EXE shadow slot: load beats consume, redirect kills whatever is held.
   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_rd_d    = slot_rd_q;
      slot_wr_d    = slot_wr_q;
      if (idex_out_fire) slot_valid_d = 1'b0;
      if (issue_fire) begin
         slot_valid_d = 1'b1;
         slot_rd_d    = id_rd;
         slot_wr_d    = id_gpr_write & (id_rd != '0);
      end
      if (redirect_i) slot_valid_d = 1'b0;
   end

   // State and slot registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         fence_kind_q <= 1'b0;
         ack_seen_q   <= 1'b0;
         slot_valid_q <= 1'b0;
         slot_rd_q    <= '0;
         slot_wr_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fence_kind_q <= fence_kind_d;
         ack_seen_q   <= ack_seen_d;
         slot_valid_q <= slot_valid_d;
         slot_rd_q    <= slot_rd_d;
         slot_wr_q    <= slot_wr_d;
      end
   end

endmodule

// File: tb/tb_ysyx_24100006_hazard_ctrl.sv
// tb/tb_ysyx_24100006_hazard_ctrl.sv - randomized and directed bench against a behavioural model
module tb_ysyx_24100006_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_rs1_used, id_rs2_used, id_gpr_write, id_is_fence_i, id_is_break;
   logic [3:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic       idex_in_ready, idex_out_fire, wb_fire, wb_gpr_write, redirect_i, icache_flush_ack;
   logic       id_issue, idex_flush, ifid_flush, icache_flush_req, halted, busy;

   always #5 clk = ~clk;

   ysyx_24100006_hazard_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .id_valid         (id_valid),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .id_rs1_used      (id_rs1_used),
      .id_rs2_used      (id_rs2_used),
      .id_rd            (id_rd),
      .id_gpr_write     (id_gpr_write),
      .id_is_fence_i    (id_is_fence_i),
      .id_is_break      (id_is_break),
      .idex_in_ready    (idex_in_ready),
      .idex_out_fire    (idex_out_fire),
      .wb_fire          (wb_fire),
      .wb_rd            (wb_rd),
      .wb_gpr_write     (wb_gpr_write),
      .redirect_i       (redirect_i),
      .icache_flush_ack (icache_flush_ack),
      .id_issue         (id_issue),
      .idex_flush       (idex_flush),
      .ifid_flush       (ifid_flush),
      .icache_flush_req (icache_flush_req),
      .halted           (halted),
      .busy             (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending-write count per register, one in-flight ID_EXE entry, a phase.
   localparam int P_RUN = 0, P_DRAIN = 1, P_ICFL = 2, P_HALT = 3;
   int m_cnt [16];
   bit m_slot_v, m_slot_wr;
   int m_slot_rd;
   int m_phase;
   bit m_is_fence, m_acked;

   function automatic bit m_hazard();
      bit h;
      h = 0;
      if (id_rs1_used && id_rs1 != 0 && m_cnt[id_rs1] > 0) h = 1;
      if (id_rs2_used && id_rs2 != 0 && m_cnt[id_rs2] > 0) h = 1;
      if (id_gpr_write && id_rd != 0 && m_cnt[id_rd] >= 3) h = 1;
      return id_valid && h;
   endfunction

   function automatic bit m_issue();
      if (m_phase == P_RUN)
         return id_valid && !m_hazard() && !redirect_i && !id_is_fence_i && !id_is_break;
      if (m_phase == P_ICFL) return m_acked && id_valid;
      return 0;
   endfunction

   task automatic m_reset();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_slot_v = 0; m_slot_wr = 0; m_slot_rd = 0;
      m_phase = P_RUN; m_is_fence = 0; m_acked = 0;
   endtask

   task automatic m_update();
      bit fire, pipe_empty;
      int nc;
      fire = m_issue() && idex_in_ready;
      pipe_empty = !m_slot_v;
      foreach (m_cnt[r]) if (m_cnt[r] != 0) pipe_empty = 0;
      case (m_phase)
         P_RUN:   if (id_valid && (id_is_fence_i || id_is_break) && !redirect_i) begin
                     m_phase = P_DRAIN; m_is_fence = id_is_fence_i;
                  end
         P_DRAIN: if (redirect_i) m_phase = P_RUN;
                  else if (pipe_empty) begin m_phase = m_is_fence ? P_ICFL : P_HALT; m_acked = 0; end
         P_ICFL:  if (m_acked && fire) begin m_phase = P_RUN; m_acked = 0; end
                  else if (icache_flush_ack) m_acked = 1;
         default: ;
      endcase
      for (int r = 1; r < 16; r++) begin
         nc = m_cnt[r];
         if (fire && id_gpr_write && id_rd == r) nc++;
         if (wb_fire && wb_gpr_write && wb_rd == r) nc--;
         if (redirect_i && m_slot_v && m_slot_wr && m_slot_rd == r) nc--;
         m_cnt[r] = (nc < 0) ? 0 : (nc > 3) ? 3 : nc;
      end
      if (idex_out_fire) m_slot_v = 0;
      if (fire) begin m_slot_v = 1; m_slot_rd = id_rd; m_slot_wr = id_gpr_write && id_rd != 0; end
      if (redirect_i) m_slot_v = 0;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = 0; id_gpr_write = 0; id_is_fence_i = 0; id_is_break = 0;
      idex_in_ready = 1; idex_out_fire = 0; wb_fire = 0; wb_rd = 0; wb_gpr_write = 0;
      redirect_i = 0; icache_flush_ack = 0;
   endtask

   // Called just after a falling edge with inputs applied; leaves at the next falling edge.
   task automatic step();
      #1;
      check_eq("id_issue", id_issue, m_issue());
      check_eq("idex_flush", idex_flush, redirect_i);
      check_eq("ifid_flush", ifid_flush, redirect_i);
      check_eq("icache_flush_req", icache_flush_req, m_phase == P_ICFL && !m_acked);
      check_eq("halted", halted, m_phase == P_HALT);
      check_eq("busy", busy, m_phase != P_RUN);
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1;
      idle();
      #1;
      check_eq("rst_issue", id_issue, 0);
      check_eq("rst_flush", {idex_flush, ifid_flush, icache_flush_req}, 0);
      check_eq("rst_halted", halted, 0);
      check_eq("rst_busy", busy, 0);
      m_reset();
      @(negedge clk);
      reset = 0;
   endtask

   task automatic writer(input int rd);
      idle(); id_valid = 1; id_rd = 4'(rd); id_gpr_write = 1;
   endtask

   task automatic reader(input int rs);
      idle(); id_valid = 1; id_rs1 = 4'(rs); id_rs1_used = 1;
   endtask

   int r;

   initial begin
      idle();
      reset = 1;
      m_reset();
      @(negedge clk);
      do_reset();

      // RAW on x5: stall until the cycle after x5 retires.
      writer(5); step();
      reader(5); idex_out_fire = 1;
      repeat (3) begin #1 check_eq("raw_stall", id_issue, 0); step(); end
      wb_fire = 1; wb_rd = 5; wb_gpr_write = 1;
      #1 check_eq("raw_wb_cycle", id_issue, 0); step();
      wb_fire = 0;
      #1 check_eq("raw_release", id_issue, 1); step();

      // Three writers of x9 saturate; a fourth stalls until one retires.
      do_reset();
      writer(9); idex_out_fire = 1;
      repeat (3) step();
      #1 check_eq("sat_stall", id_issue, 0); step();
      wb_fire = 1; wb_rd = 9; wb_gpr_write = 1; step();
      wb_fire = 0;
      #1 check_eq("sat_release", id_issue, 1); step();

      // Redirect kills a pending x3 write held in the slot.
      do_reset();
      writer(3); step();
      idle(); redirect_i = 1;
      #1 check_eq("redir_idex_flush", idex_flush, 1);
      check_eq("redir_ifid_flush", ifid_flush, 1);
      step();
      reader(3);
      #1 check_eq("redir_cnt_cleared", id_issue, 1); step();

      // x7 issue and retire together nets zero; x0 never tracked.
      do_reset();
      writer(7); wb_fire = 1; wb_rd = 7; wb_gpr_write = 1; step();
      reader(7);
      #1 check_eq("same_cycle_net0", id_issue, 1); step();
      writer(0); step();
      reader(0); id_rs2_used = 1;
      #1 check_eq("x0_no_stall", id_issue, 1); step();

      // fence.i with two writes outstanding.
      do_reset();
      writer(1); step();
      writer(2); step();
      idle(); id_valid = 1; id_is_fence_i = 1; idex_out_fire = 1; step();
      #1 check_eq("fence_drain_busy", busy, 1);
      check_eq("fence_drain_noissue", id_issue, 0); step();
      wb_fire = 1; wb_gpr_write = 1; wb_rd = 1; step();
      wb_rd = 2; step();
      wb_fire = 0;
      r = 0;
      while (!icache_flush_req && r < 10) begin step(); r++; end
      check_eq("fence_req_seen", icache_flush_req, 1);
      icache_flush_ack = 1; step();
      icache_flush_ack = 0;
      #1 check_eq("fence_one_issue", id_issue, 1); step();
      id_valid = 0; id_is_fence_i = 0;
      #1 check_eq("fence_back_run", busy, 0); step();

      // Randomized traffic, occasional fence.i, then an asynchronous reset mid-flight.
      do_reset();
      repeat (2000) begin
         id_valid      = ($urandom % 4) != 0;
         id_rs1        = 4'($urandom); id_rs2 = 4'($urandom); id_rd = 4'($urandom);
         id_rs1_used   = 1'($urandom); id_rs2_used = 1'($urandom);
         id_gpr_write  = ($urandom % 4) != 0;
         id_is_fence_i = ($urandom % 40) == 0;
         id_is_break   = 0;
         idex_in_ready = ($urandom % 4) != 0;
         idex_out_fire = 1'($urandom);
         r             = int'($urandom_range(1, 15));
         wb_rd         = 4'(r);
         wb_gpr_write  = ($urandom % 8) != 0;
         wb_fire       = (m_cnt[r] > 0) && ($urandom % 4 != 0);
         redirect_i    = (m_phase != P_ICFL) && ($urandom % 10 == 0);
         icache_flush_ack = (m_phase == P_ICFL) && !m_acked && ($urandom % 4 == 0);
         step();
      end
      do_reset();
      step();

      // ebreak: drain, halt, stay halted whatever the inputs, then reset clears it.
      idle(); id_valid = 1; id_is_break = 1; step();
      idle();
      r = 0;
      while (!halted && r < 10) begin step(); r++; end
      check_eq("break_halted", halted, 1);
      repeat (100) begin
         id_valid = 1'($urandom); id_rs1 = 4'($urandom); id_rd = 4'($urandom);
         id_gpr_write = 1'($urandom); idex_in_ready = 1'($urandom);
         #1 check_eq("halt_no_issue", id_issue, 0);
         step();
      end
      do_reset();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
